// File: rtl/mdu_hilo_pkg.sv
// Package for the multiply/divide unit: operation encoding, FSM state
// encoding and small operation-class helpers shared by the top level,
// the divider core, the bus interface and the testbench.
package mdu_pkg;

    // Operation requested on the bus.
    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } mdu_op_t;

    // Control FSM states of mdu_hilo.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_RUN  = 2'd2,
        DIV_FIX  = 2'd3
    } mdu_state_t;

    // True for the two multiply operations.
    function automatic logic is_mul(input mdu_op_t op);
        return (op == MULT) || (op == MULTU);
    endfunction

    // True for the two divide operations.
    function automatic logic is_div(input mdu_op_t op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/mdu_hilo_if.sv
// Request/response bus between the control unit (master) and the
// multiply/divide unit (slave).
//   start   : request strobe, held by the master until accepted
//   op      : operation (mdu_op_t)
//   op1/op2 : rs / rt operands
//   rd_hilo : datapath is reading HI or LO this cycle
//   hi/lo   : HI and LO registers
//   busy    : operation in flight
//   done    : one-cycle pulse after a MULT*/DIV* result lands in hi/lo
//   stall   : combinational stall request to the control unit
interface mdu_hilo_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic             start;
    mdu_op_t          op;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic             rd_hilo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, op, op1, op2, rd_hilo,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, op, op1, op2, rd_hilo,
        output hi, lo, busy, done, stall
    );

endinterface

// File: rtl/mdu_hilo_divider.sv
// Iterative restoring divider core.
// Operands are latched on start_i; magnitudes are divided one quotient bit
// per cycle for WIDTH cycles, then a single fix-up cycle presents the
// sign-corrected (or special-case) result with valid_o high.
//   clk, rst_n : clock, asynchronous active-low reset
//   start_i    : latch operands and begin a division
//   signed_i   : treat operands as two's complement
//   op1_i      : dividend
//   op2_i      : divisor
//   quot_o     : quotient (valid while valid_o)
//   rem_o      : remainder (valid while valid_o)
//   valid_o    : result is presented this cycle
module mdu_hilo_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o,
    output logic             valid_o
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

    logic             run_q;
    logic             fix_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] quo_q;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] dividend_q; // original dividend, returned as remainder on /0
    logic             neg_q_q;
    logic             neg_r_q;
    logic             dvz_q;
    logic             ovf_q;

    logic [WIDTH-1:0] op1_abs_s;
    logic [WIDTH-1:0] op2_abs_s;
    logic [WIDTH:0]   shift_s;
    logic             ge_s;
    logic [WIDTH-1:0] diff_s;

    // Operand magnitudes for the unsigned core.
    always_comb begin
        op1_abs_s = (signed_i && op1_i[WIDTH-1]) ? -op1_i : op1_i;
        op2_abs_s = (signed_i && op2_i[WIDTH-1]) ? -op2_i : op2_i;
    end

    // One restoring step. The partial remainder is always below the divisor,
    // so when the trial subtraction succeeds its result fits in WIDTH bits.
    always_comb begin
        shift_s = {rem_q, quo_q[WIDTH-1]};
        ge_s    = (shift_s >= {1'b0, divisor_q});
        diff_s  = shift_s[WIDTH-1:0] - divisor_q;
    end

    // Operand capture, iteration and fix-up sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q      <= 1'b0;
            fix_q      <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            divisor_q  <= ZERO_W;
            quo_q      <= ZERO_W;
            rem_q      <= ZERO_W;
            dividend_q <= ZERO_W;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            dvz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else if (start_i) begin
            run_q      <= 1'b1;
            fix_q      <= 1'b0;
            cnt_q      <= {CNT_W{1'b0}};
            divisor_q  <= op2_abs_s;
            quo_q      <= op1_abs_s;
            rem_q      <= ZERO_W;
            dividend_q <= op1_i;
            neg_q_q    <= signed_i && (op1_i[WIDTH-1] ^ op2_i[WIDTH-1]);
            neg_r_q    <= signed_i && op1_i[WIDTH-1];
            dvz_q      <= (op2_i == ZERO_W);
            ovf_q      <= signed_i && (op1_i == MIN_INT) && (op2_i == ALL_ONES);
        end else if (run_q) begin
            quo_q <= {quo_q[WIDTH-2:0], ge_s};
            rem_q <= ge_s ? diff_s : shift_s[WIDTH-1:0];
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                run_q <= 1'b0;
                fix_q <= 1'b1;
            end
        end else begin
            fix_q <= 1'b0;
        end
    end

    // Sign correction and architecturally defined special results.
    always_comb begin
        quot_o  = quo_q;
        rem_o   = rem_q;
        valid_o = fix_q;
        if (dvz_q) begin
            quot_o = ALL_ONES;
            rem_o  = dividend_q;
        end else if (ovf_q) begin
            quot_o = MIN_INT;
            rem_o  = ZERO_W;
        end else begin
            quot_o = neg_q_q ? -quo_q : quo_q;
            rem_o  = neg_r_q ? -rem_q : rem_q;
        end
    end

endmodule

// File: rtl/mdu_hilo.sv
// Multi-cycle multiply/divide unit owning the HI/LO register pair.
// MULT/MULTU: 2*WIDTH product through a MUL_CYCLES-deep pipeline.
// DIV/DIVU:   restoring divider, fixed WIDTH+1 cycle latency.
// MTHI/MTLO:  written on the accepting edge, no busy period.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mdu_hilo_if slave (start/op/op1/op2/rd_hilo in;
//           hi/lo/busy/done/stall out)
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    mdu_hilo_if.slave    bus
);

    localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [WIDTH-1:0]   ZERO_W  = {WIDTH{1'b0}};
    localparam logic [2*WIDTH-1:0] ZERO_2W = {(2*WIDTH){1'b0}};

    mdu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [2*WIDTH-1:0] prod_pipe_q [MUL_CYCLES];

    logic               accept_s;
    logic               mul_accept_s;
    logic               div_start_s;
    logic [2*WIDTH-1:0] mul_a_s;
    logic [2*WIDTH-1:0] mul_b_s;
    logic [2*WIDTH-1:0] product_s;
    logic [WIDTH-1:0]   div_quot_s;
    logic [WIDTH-1:0]   div_rem_s;
    logic               div_valid_s;

    assign accept_s     = bus.start && !busy_q;
    assign mul_accept_s = accept_s && is_mul(bus.op);
    assign div_start_s  = accept_s && is_div(bus.op);

    // Extend to 2*WIDTH so a plain truncated multiply yields the exact
    // signed or unsigned product.
    always_comb begin
        if (bus.op == MULT) begin
            mul_a_s = {{WIDTH{bus.op1[WIDTH-1]}}, bus.op1};
            mul_b_s = {{WIDTH{bus.op2[WIDTH-1]}}, bus.op2};
        end else begin
            mul_a_s = {ZERO_W, bus.op1};
            mul_b_s = {ZERO_W, bus.op2};
        end
        product_s = mul_a_s * mul_b_s;
    end

    // Product register: loaded only when a multiply is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_pipe_q[0] <= ZERO_2W;
        end else if (mul_accept_s) begin
            prod_pipe_q[0] <= product_s;
        end else begin
            prod_pipe_q[0] <= prod_pipe_q[0];
        end
    end

    // Remaining MUL_CYCLES-1 pipeline stages; the last stage holds the
    // product on the cycle before hi/lo are written.
    for (genvar g = 1; g < MUL_CYCLES; g++) begin : g_mul_pipe
        // One delay stage of the product pipeline.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                prod_pipe_q[g] <= ZERO_2W;
            end else begin
                prod_pipe_q[g] <= prod_pipe_q[g-1];
            end
        end
    end

    mdu_hilo_divider #(
        .WIDTH (WIDTH)
    ) u_divider (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (div_start_s),
        .signed_i (bus.op == DIV),
        .op1_i    (bus.op1),
        .op2_i    (bus.op2),
        .quot_o   (div_quot_s),
        .rem_o    (div_rem_s),
        .valid_o  (div_valid_s)
    );

    // Control FSM: next state, latency counter and HI/LO update selection.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    case (bus.op)
                        MULT, MULTU: begin
                            state_d = MUL_WAIT;
                            cnt_d   = {CNT_W{1'b0}};
                            busy_d  = 1'b1;
                        end
                        DIV, DIVU: begin
                            state_d = DIV_RUN;
                            cnt_d   = {CNT_W{1'b0}};
                            busy_d  = 1'b1;
                        end
                        MTHI: begin
                            hi_d = bus.op1;
                        end
                        MTLO: begin
                            lo_d = bus.op1;
                        end
                        default: begin
                            state_d = IDLE;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            MUL_WAIT: begin
                if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                    hi_d    = prod_pipe_q[MUL_CYCLES-1][2*WIDTH-1:WIDTH];
                    lo_d    = prod_pipe_q[MUL_CYCLES-1][WIDTH-1:0];
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DIV_RUN: begin
                // The divider iterates in lockstep; after WIDTH steps its
                // fix-up cycle coincides with DIV_FIX.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DIV_FIX;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DIV_FIX: begin
                if (div_valid_s) begin
                    hi_d    = div_rem_s;
                    lo_d    = div_quot_s;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = DIV_FIX;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, status and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= ZERO_W;
            lo_q    <= ZERO_W;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    // Combinational so the control unit can hold a request or an MFHI/MFLO
    // in the very cycle it would otherwise proceed.
    assign bus.stall = busy_q && (bus.start || bus.rd_hilo);

endmodule
